// File: rtl/glitcbus_region_arbiter.sv
// GLITCBUS region arbiter: decodes the bus address into register regions and a
// sample-storage window, issues registered strobes to the target, waits for the
// read acknowledge with a timeout and logs faulted accesses.
module glitcbus_region_arbiter #(
    parameter int unsigned             NUM_REGIONS = 8,
    parameter int unsigned             REGION_BITS = 4,
    parameter int unsigned             SAMPLE_BIT  = 11,
    parameter int unsigned             ADDR_WIDTH  = 16,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter logic [15:0]             ACK_MASK    = 16'h0000,
    parameter int unsigned             TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0]   ERR_PATTERN = 32'hBAD0ADD0
) (
    input  logic                              user_clk_i,
    input  logic                              user_rst_i,
    input  logic [ADDR_WIDTH-1:0]             gb_adr_i,
    input  logic [DATA_WIDTH-1:0]             gb_dat_i,
    input  logic                              gb_wr_i,
    input  logic                              gb_rd_i,
    output logic [DATA_WIDTH-1:0]             gb_dat_o,
    output logic                              gb_ack_o,
    output logic [NUM_REGIONS-1:0]            user_sel_o,
    output logic                              sample_sel_o,
    output logic                              user_wr_o,
    output logic                              user_rd_o,
    output logic [ADDR_WIDTH-1:0]             user_adr_o,
    output logic [DATA_WIDTH-1:0]             user_dat_o,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_dat_i,
    input  logic [NUM_REGIONS-1:0]            region_ack_i,
    input  logic [DATA_WIDTH-1:0]             sample_dat_i,
    input  logic                              sample_ack_i,
    output logic [7:0]                        err_count_o,
    output logic [ADDR_WIDTH-1:0]             err_adr_o
);

    localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT
    } state_t;

    state_t                   r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0]    r_adr, w_adr_nx;
    logic [DATA_WIDTH-1:0]    r_dat, w_dat_nx;
    logic [NUM_REGIONS-1:0]   r_sel, w_sel_nx;
    logic                     r_ssel, w_ssel_nx;
    logic                     r_wr, w_wr_nx;
    logic                     r_rd, w_rd_nx;
    logic                     r_is_wr, w_is_wr_nx;
    logic                     r_is_smp, w_is_smp_nx;
    logic                     r_unm, w_unm_nx;
    logic [IDX_W-1:0]         r_idx, w_idx_nx;
    logic [7:0]               r_cnt, w_cnt_nx;
    logic [DATA_WIDTH-1:0]    r_gb_dat, w_gb_dat_nx;
    logic                     r_gb_ack, w_gb_ack_nx;
    logic [7:0]               r_err_cnt, w_err_cnt_nx;
    logic [ADDR_WIDTH-1:0]    r_err_adr, w_err_adr_nx;

    logic                     w_in_smp;
    logic [IDX_W-1:0]         w_in_idx;
    logic                     w_in_unm;
    logic [NUM_REGIONS-1:0]   w_in_sel;
    logic [DATA_WIDTH-1:0]    w_rdat;
    logic                     w_rack;
    logic                     w_use_ack;
    logic                     w_tgt_ack;
    logic [DATA_WIDTH-1:0]    w_tgt_dat;
    logic [1:0]               w_req_n;
    logic                     w_cmp_flt;
    logic [1:0]               w_nflt;
    logic [8:0]               w_sum;

    // Address decode of the incoming request and data/ack mux of the latched target
    always_comb begin
        w_in_smp = gb_adr_i[SAMPLE_BIT];
        w_in_idx = (NUM_REGIONS == 1) ? '0 : gb_adr_i[REGION_BITS +: IDX_W];
        w_in_unm = !w_in_smp && (32'(w_in_idx) >= NUM_REGIONS);
        w_in_sel = '0;
        w_rdat    = '0;
        w_rack    = 1'b0;
        w_use_ack = 1'b0;
        for (int unsigned n = 0; n < NUM_REGIONS; n++) begin
            w_in_sel[n] = !w_in_smp && !w_in_unm && (32'(w_in_idx) == n);
            if (32'(r_idx) == n) begin
                w_rdat    = region_dat_i[n*DATA_WIDTH +: DATA_WIDTH];
                w_rack    = region_ack_i[n];
                w_use_ack = ACK_MASK[n];
            end
        end
        w_tgt_ack = r_is_smp ? sample_ack_i : (w_use_ack ? w_rack : 1'b1);
        w_tgt_dat = r_is_smp ? sample_dat_i : w_rdat;
    end

    // Next-state and next-register logic for the access FSM and fault log
    always_comb begin
        w_state_nx   = r_state;
        w_adr_nx     = r_adr;
        w_dat_nx     = r_dat;
        w_sel_nx     = r_sel;
        w_ssel_nx    = r_ssel;
        w_wr_nx      = 1'b0;
        w_rd_nx      = 1'b0;
        w_is_wr_nx   = r_is_wr;
        w_is_smp_nx  = r_is_smp;
        w_unm_nx     = r_unm;
        w_idx_nx     = r_idx;
        w_cnt_nx     = r_cnt;
        w_gb_dat_nx  = r_gb_dat;
        w_gb_ack_nx  = 1'b0;
        w_req_n      = '0;
        w_cmp_flt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (gb_wr_i) begin
                    w_adr_nx    = gb_adr_i;
                    w_dat_nx    = gb_dat_i;
                    w_is_smp_nx = w_in_smp;
                    w_unm_nx    = w_in_unm;
                    w_idx_nx    = w_in_idx;
                    w_is_wr_nx  = 1'b1;
                    // a read arriving with the write is dropped; an unmapped write is also a fault
                    w_req_n     = {1'b0, gb_rd_i} + {1'b0, w_in_unm};
                    if (!w_in_unm) begin
                        w_sel_nx   = w_in_sel;
                        w_ssel_nx  = w_in_smp;
                        w_wr_nx    = 1'b1;
                        w_state_nx = S_STROBE;
                    end
                end else if (gb_rd_i) begin
                    w_adr_nx    = gb_adr_i;
                    w_is_smp_nx = w_in_smp;
                    w_unm_nx    = w_in_unm;
                    w_idx_nx    = w_in_idx;
                    w_is_wr_nx  = 1'b0;
                    if (w_in_unm) begin
                        w_state_nx = S_WAIT;
                    end else begin
                        w_sel_nx   = w_in_sel;
                        w_ssel_nx  = w_in_smp;
                        w_rd_nx    = 1'b1;
                        w_state_nx = S_STROBE;
                    end
                end
            end
            S_STROBE: begin
                w_req_n = {1'b0, gb_wr_i} + {1'b0, gb_rd_i};
                if (r_is_wr) begin
                    w_sel_nx   = '0;
                    w_ssel_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req_n = {1'b0, gb_wr_i} + {1'b0, gb_rd_i};
                if (r_unm) begin
                    w_gb_dat_nx = ERR_PATTERN;
                    w_gb_ack_nx = 1'b1;
                    w_cmp_flt   = 1'b1;
                    w_state_nx  = S_IDLE;
                end else if (w_tgt_ack) begin
                    w_gb_dat_nx = w_tgt_dat;
                    w_gb_ack_nx = 1'b1;
                    w_sel_nx    = '0;
                    w_ssel_nx   = 1'b0;
                    w_state_nx  = S_IDLE;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_gb_dat_nx = ERR_PATTERN;
                    w_gb_ack_nx = 1'b1;
                    w_cmp_flt   = 1'b1;
                    w_sel_nx    = '0;
                    w_ssel_nx   = 1'b0;
                    w_state_nx  = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // a new offending request is more recent than a completing one in the same cycle
        w_nflt       = w_req_n + {1'b0, w_cmp_flt};
        w_sum        = {1'b0, r_err_cnt} + {7'b0, w_nflt};
        w_err_cnt_nx = w_sum[8] ? 8'hFF : w_sum[7:0];
        if (w_req_n != '0) begin
            w_err_adr_nx = gb_adr_i;
        end else if (w_cmp_flt) begin
            w_err_adr_nx = r_adr;
        end else begin
            w_err_adr_nx = r_err_adr;
        end
    end

    // FSM state register
    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath, strobe and fault-log registers
    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_ssel    <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_is_wr   <= 1'b0;
            r_is_smp  <= 1'b0;
            r_unm     <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_gb_dat  <= '0;
            r_gb_ack  <= 1'b0;
            r_err_cnt <= '0;
            r_err_adr <= '0;
        end else begin
            r_adr     <= w_adr_nx;
            r_dat     <= w_dat_nx;
            r_sel     <= w_sel_nx;
            r_ssel    <= w_ssel_nx;
            r_wr      <= w_wr_nx;
            r_rd      <= w_rd_nx;
            r_is_wr   <= w_is_wr_nx;
            r_is_smp  <= w_is_smp_nx;
            r_unm     <= w_unm_nx;
            r_idx     <= w_idx_nx;
            r_cnt     <= w_cnt_nx;
            r_gb_dat  <= w_gb_dat_nx;
            r_gb_ack  <= w_gb_ack_nx;
            r_err_cnt <= w_err_cnt_nx;
            r_err_adr <= w_err_adr_nx;
        end
    end

    assign gb_dat_o     = r_gb_dat;
    assign gb_ack_o     = r_gb_ack;
    assign user_sel_o   = r_sel;
    assign sample_sel_o = r_ssel;
    assign user_wr_o    = r_wr;
    assign user_rd_o    = r_rd;
    assign user_adr_o   = r_adr;
    assign user_dat_o   = r_dat;
    assign err_count_o  = r_err_cnt;
    assign err_adr_o    = r_err_adr;

endmodule

// File: tb/tb_glitcbus_region_arbiter.sv
// Scoreboard bench for glitcbus_region_arbiter: six regions, region 4 acked,
// the rest fixed latency; randomized reads/writes, stray requests and acks.
module tb_glitcbus_region_arbiter;

    localparam int          NR  = 6;
    localparam int          DW  = 32;
    localparam int          AW  = 16;
    localparam int          TMO = 15;
    localparam logic [31:0] ERR = 32'hBAD0ADD0;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     gb_adr_i;
    logic [DW-1:0]     gb_dat_i;
    logic              gb_wr_i;
    logic              gb_rd_i;
    logic [DW-1:0]     gb_dat_o;
    logic              gb_ack_o;
    logic [NR-1:0]     user_sel_o;
    logic              sample_sel_o;
    logic              user_wr_o;
    logic              user_rd_o;
    logic [AW-1:0]     user_adr_o;
    logic [DW-1:0]     user_dat_o;
    logic [NR*DW-1:0]  region_dat_i;
    logic [NR-1:0]     region_ack_i;
    logic [DW-1:0]     sample_dat_i;
    logic              sample_ack_i;
    logic [7:0]        err_count_o;
    logic [AW-1:0]     err_adr_o;

    glitcbus_region_arbiter #(
        .NUM_REGIONS (NR),
        .ACK_MASK    (16'h0010),
        .TIMEOUT     (TMO)
    ) dut (
        .user_clk_i   (clk),
        .user_rst_i   (rst),
        .gb_adr_i     (gb_adr_i),
        .gb_dat_i     (gb_dat_i),
        .gb_wr_i      (gb_wr_i),
        .gb_rd_i      (gb_rd_i),
        .gb_dat_o     (gb_dat_o),
        .gb_ack_o     (gb_ack_o),
        .user_sel_o   (user_sel_o),
        .sample_sel_o (sample_sel_o),
        .user_wr_o    (user_wr_o),
        .user_rd_o    (user_rd_o),
        .user_adr_o   (user_adr_o),
        .user_dat_o   (user_dat_o),
        .region_dat_i (region_dat_i),
        .region_ack_i (region_ack_i),
        .sample_dat_i (sample_dat_i),
        .sample_ack_i (sample_ack_i),
        .err_count_o  (err_count_o),
        .err_adr_o    (err_adr_o)
    );

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } ack_t;

    typedef struct {
        logic [NR-1:0] sel;
        logic          ssel;
        logic          wr;
        logic          rd;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            cyc;
    } stb_t;

    ack_t          ack_q[$];
    stb_t          stb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            m_err_cnt = 0;
    logic [AW-1:0] m_err_adr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Fault log model: saturating count, most recent offending address
    function automatic void add_flt(input int n, input logic [AW-1:0] a);
        if (n > 0) begin
            m_err_cnt = m_err_cnt + n;
            if (m_err_cnt > 255) m_err_cnt = 255;
            m_err_adr = a;
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a strobe
    always @(negedge clk) begin : monitor
        ack_t a;
        stb_t s;
        if (gb_ack_o) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {96'd0, gb_dat_o}, 128'h1_0000_0000);
            end else begin
                a = ack_q.pop_front();
                chk("ack_data", gb_dat_o, a.dat);
                chk("ack_cycle", cyc, a.cyc);
            end
        end
        if (user_wr_o || user_rd_o) begin
            if (stb_q.size() == 0) begin
                chk("unexpected_strobe", {user_wr_o, user_rd_o, user_adr_o}, '0);
            end else begin
                s = stb_q.pop_front();
                chk("strobe_cycle", cyc, s.cyc);
                chk("strobe_sel", {user_sel_o, sample_sel_o}, {s.sel, s.ssel});
                chk("strobe_kind", {user_wr_o, user_rd_o}, {s.wr, s.rd});
                chk("strobe_adr", user_adr_o, s.adr);
                if (s.wr) chk("strobe_wdat", user_dat_o, s.dat);
            end
        end
    end

    // One bus access: model pushes expectations, then drives inputs cycle by cycle
    task automatic txn(input bit do_wr, input bit do_rd, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input int d, input int inj,
                       input logic [AW-1:0] inj_adr);
        int            c;
        int            endk;
        int            lim;
        int            idx;
        bit            smp;
        bit            unm;
        bit            usea;
        bit            rd_only;
        bit            tmo_flt;
        logic [NR-1:0] sel;
        logic [DW-1:0] exp_d;

        for (int i = 0; i < NR; i++) region_dat_i[i*DW +: DW] = $urandom;
        sample_dat_i = $urandom;
        @(posedge clk);
        #1;
        c       = cyc;
        smp     = adr[11];
        idx     = int'(adr[6:4]);
        unm     = !smp && (idx >= NR);
        usea    = smp || (idx == 4);
        rd_only = do_rd && !do_wr;
        tmo_flt = 1'b0;
        sel     = '0;
        if (!smp && !unm) sel[idx] = 1'b1;
        if (do_wr && unm) inj = 0;
        if (!do_wr && !do_rd) inj = 0;
        endk = 2;

        if (do_wr) begin
            if (unm) begin
                add_flt(1 + int'(do_rd), adr);
            end else begin
                stb_q.push_back('{sel, smp, 1'b1, 1'b0, adr, dat, c + 1});
                if (do_rd) add_flt(1, adr);
            end
        end else if (do_rd) begin
            if (unm) begin
                ack_q.push_back('{ERR, c + 2});
                add_flt(1, adr);
            end else begin
                stb_q.push_back('{sel, smp, 1'b0, 1'b1, adr, '0, c + 1});
                exp_d = smp ? sample_dat_i : region_dat_i[idx*DW +: DW];
                if (!usea) begin
                    ack_q.push_back('{exp_d, c + 3});
                    endk = 3;
                end else if (d <= TMO) begin
                    ack_q.push_back('{exp_d, c + 2 + d});
                    endk = 2 + d;
                end else begin
                    ack_q.push_back('{ERR, c + 2 + TMO});
                    endk = 2 + TMO;
                    tmo_flt = 1'b1;
                end
            end
        end
        add_flt(int'(inj[0]) + int'(inj[1]), inj_adr);
        if (tmo_flt) add_flt(1, adr);

        lim = endk + 2;
        if (rd_only && usea && (d + 3 > lim)) lim = d + 3;
        for (int k = 0; k <= lim; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            gb_wr_i  = ((k == 0) && do_wr) || ((k == 1) && inj[1]);
            gb_rd_i  = ((k == 0) && do_rd) || ((k == 1) && inj[0]);
            gb_adr_i = ((k == 1) && (inj != 0)) ? inj_adr : adr;
            gb_dat_i = (k == 0) ? dat : $urandom;
            region_ack_i = NR'($urandom);
            if (rd_only && !unm && !smp && (idx == 4)) region_ack_i[4] = (k == 1 + d);
            sample_ack_i = (rd_only && smp) ? (k == 1 + d) : 1'($urandom);
        end

        chk("err_count", err_count_o, m_err_cnt);
        chk("err_adr", err_adr_o, m_err_adr);
        chk("sel_idle", {user_sel_o, sample_sel_o}, '0);
        chk("ack_q_drained", ack_q.size(), 0);
        chk("stb_q_drained", stb_q.size(), 0);
    endtask

    task automatic rst_mid_wait();
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        stb_q.push_back('{6'h10, 1'b0, 1'b0, 1'b1, 16'h0041, '0, c + 1});
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            gb_rd_i      = (k == 0);
            gb_wr_i      = 1'b0;
            gb_adr_i     = 16'h0041;
            region_ack_i = '0;
            sample_ack_i = 1'b0;
            rst          = (k == 5);
            if (k == 7) begin
                m_err_cnt = 0;
                m_err_adr = '0;
                chk("rst_mid_sel", {user_sel_o, sample_sel_o, user_wr_o, user_rd_o}, '0);
                chk("rst_mid_gb", {gb_ack_o, gb_dat_o}, '0);
                chk("rst_mid_err", {err_count_o, err_adr_o}, {8'(m_err_cnt), m_err_adr});
                chk("rst_mid_lat", {user_adr_o, user_dat_o}, '0);
            end
        end
        chk("rst_mid_stb_q", stb_q.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [AW-1:0] a;
        logic [AW-1:0] ia;
        int            cat;
        int            op;
        int            pick;
        int            inj;

        rst          = 1'b1;
        gb_adr_i     = '0;
        gb_dat_i     = '0;
        gb_wr_i      = 1'b0;
        gb_rd_i      = 1'b0;
        region_dat_i = '0;
        region_ack_i = '0;
        sample_dat_i = '0;
        sample_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gb", {gb_ack_o, gb_dat_o}, '0);
        chk("rst_strobes", {user_sel_o, sample_sel_o, user_wr_o, user_rd_o}, '0);
        chk("rst_latch", {user_adr_o, user_dat_o}, '0);
        chk("rst_err", {err_count_o, err_adr_o}, '0);
        rst = 1'b0;

        txn(0, 1, 16'h0023, '0, 1, 0, '0);
        txn(0, 1, 16'h0041, '0, 5, 0, '0);
        txn(0, 1, 16'h0041, '0, 40, 0, '0);
        txn(0, 1, 16'h0041, '0, 15, 0, '0);
        txn(0, 1, 16'h0041, '0, 16, 0, '0);
        txn(1, 0, 16'h0805, 32'hA5A5A5A5, 1, 0, '0);
        txn(0, 1, 16'h0070, '0, 1, 0, '0);
        txn(0, 1, 16'h0841, '0, 3, 0, '0);
        txn(0, 1, 16'h0023, '0, 1, 1, 16'h0033);
        txn(0, 1, 16'h0041, '0, 6, 3, 16'h0155);
        txn(1, 1, 16'h0012, 32'h0000_0055, 1, 0, '0);
        txn(1, 0, 16'h0060, 32'h1234_5678, 1, 0, '0);
        txn(0, 1, 16'h0060, '0, 1, 2, 16'h0777);

        for (int t = 0; t < 200; t++) begin
            a   = AW'($urandom);
            cat = $urandom_range(0, 4);
            if (cat == 0) begin
                pick = $urandom_range(0, 4);
                if (pick == 4) pick = 5;
                a[11]  = 1'b0;
                a[6:4] = 3'(pick);
            end else if (cat == 1) begin
                a[11]  = 1'b0;
                a[6:4] = 3'd4;
            end else if (cat == 2) begin
                a[11]  = 1'b0;
                a[6:4] = 3'($urandom_range(6, 7));
            end else if (cat == 3) begin
                a[11]  = 1'b1;
            end
            op  = $urandom_range(0, 5);
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ia  = AW'($urandom);
            txn(op <= 1 || op == 5, op >= 2, a, $urandom, $urandom_range(1, 20), inj, ia);
        end

        for (int t = 0; t < 300; t++) begin
            txn(0, 1, 16'h0070, '0, 1, 0, '0);
        end
        chk("err_saturated", err_count_o, 8'd255);

        rst_mid_wait();
        txn(0, 1, 16'h0023, '0, 1, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
